// File: rtl/sap1_ctrl_pkg.sv
// Shared constants for the SAP-1 control sequencer: opcodes, control-word bit
// positions, the idle control word and the one-hot T-state encoding.
// Pure declarations; no logic, no latency, no flow control.
package sap1_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word layout {CP,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
  localparam int CW_CP  = 11;
  localparam int CW_EP  = 10;
  localparam int CW_NLM = 9;
  localparam int CW_NCE = 8;
  localparam int CW_NLI = 7;
  localparam int CW_NEI = 6;
  localparam int CW_NLA = 5;
  localparam int CW_EA  = 4;
  localparam int CW_SU  = 3;
  localparam int CW_EU  = 2;
  localparam int CW_NLB = 1;
  localparam int CW_NLO = 0;

  // Every active-low strobe high, every active-high strobe low.
  localparam logic [11:0] CW_IDLE = 12'h3E3;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  // Opcodes with no defined micro-program.
  function automatic logic is_undef_op(input logic [3:0] op);
    return (op >= 4'h3) && (op <= 4'hD);
  endfunction

endpackage

// File: rtl/sap1_tstate_counter.sv
// One-hot T1..T6 ring counter for the SAP-1 sequencer, advancing on the falling edge.
// Latency: one falling edge per step; 'last' wraps to T1 on the next falling edge.
// Backpressure: 'hold' freezes the ring (pause/halt); 'hold' wins over 'last'.
// Ports: clk, clr (async active-high, forces T1), last, hold, t_state[5:0] one-hot.
module sap1_tstate_counter
  import sap1_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       last,
  input  logic       hold,
  output logic [5:0] t_state
);

  tstate_e state_q;
  tstate_e state_d;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) state_q <= T1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (hold) begin
      state_d = state_q;
    end else if (last) begin
      state_d = T1;
    end else begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        // Any corrupted encoding recovers to a clean fetch.
        default: state_d = T1;
      endcase
    end
  end

  assign t_state = state_q;

endmodule

// File: rtl/sap1_sequencer.sv
// SAP-1 control sequencer: T-state ring plus microcode decode to the 12-bit control word.
// Latency: control word is combinational from t_state/op_code; state and flags update on falling edge.
// Backpressure: run=0 parks at T1 (instruction boundary) with IDLE; HLT/trap freezes at T4 until clr.
// Ports: clk, clr (async active-high), run, op_code[3:0] -> cont_signal[11:0], t_state[5:0],
//        halted, instr_done, illegal.
// Build option: define SAP1_ILLEGAL_TRAP_EN to trap opcodes 3..D (sets illegal and halted).
module sap1_sequencer
  import sap1_ctrl_pkg::*;
#(
  parameter bit         EARLY_END  = 1'b1,
  parameter logic [3:0] HLT_OPCODE = OP_HLT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [3:0]  op_code,
  output logic [11:0] cont_signal,
  output logic [5:0]  t_state,
  output logic        halted,
  output logic        instr_done,
  output logic        illegal
);

  logic        is_hlt;
  logic        trap_op;
  logic        is_nop;
  logic        stop_now;
  logic        pause;
  logic        last_state;
  logic        hold;
  logic        halted_q;
  logic [11:0] cw_rom;

  assign is_hlt = (op_code == HLT_OPCODE);

`ifdef SAP1_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap_op = is_undef_op(op_code) && !is_hlt;
`else
  assign trap_op = 1'b0;
`endif

  // Anything without its own micro-program that neither halts nor traps.
  assign is_nop = !is_hlt && !trap_op &&
                  (op_code != OP_LDA) && (op_code != OP_ADD) &&
                  (op_code != OP_SUB) && (op_code != OP_OUT);

  // Opcode is only valid from T4, so halting is decided there.
  assign stop_now = (t_state == T4) && !halted_q && (is_hlt || trap_op);

  // Pause only at the instruction boundary; a running instruction always completes.
  assign pause = (t_state == T1) && !run && !halted_q;

  always_comb begin
    last_state = (t_state == T6);
    if (EARLY_END) begin
      if ((t_state == T5) && (op_code == OP_LDA) && !is_hlt)
        last_state = 1'b1;
      if ((t_state == T4) && ((op_code == OP_OUT && !is_hlt) || is_nop))
        last_state = 1'b1;
    end
  end

  assign hold       = halted_q || stop_now || pause;
  assign instr_done = last_state && !halted_q && !stop_now;

  sap1_tstate_counter u_tstate (
    .clk     (clk),
    .clr     (clr),
    .last    (last_state),
    .hold    (hold),
    .t_state (t_state)
  );

  always_ff @(negedge clk or posedge clr) begin
    if (clr)           halted_q <= 1'b0;
    else if (stop_now) halted_q <= 1'b1;
  end

`ifdef SAP1_ILLEGAL_TRAP_EN
  always_ff @(negedge clk or posedge clr) begin
    if (clr)                      illegal_q <= 1'b0;
    else if (stop_now && trap_op) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Microcode ROM: T-state x opcode. Unlisted combinations stay IDLE.
  always_comb begin
    cw_rom = CW_IDLE;
    case (t_state)
      T1: begin
        cw_rom[CW_EP]  = 1'b1;
        cw_rom[CW_NLM] = 1'b0;
      end
      T2: cw_rom[CW_CP] = 1'b1;
      T3: begin
        cw_rom[CW_NCE] = 1'b0;
        cw_rom[CW_NLI] = 1'b0;
      end
      T4: begin
        if (!is_hlt) begin
          case (op_code)
            OP_LDA, OP_ADD, OP_SUB: begin
              cw_rom[CW_NEI] = 1'b0;
              cw_rom[CW_NLM] = 1'b0;
            end
            OP_OUT: begin
              cw_rom[CW_EA]  = 1'b1;
              cw_rom[CW_NLO] = 1'b0;
            end
            default: cw_rom = CW_IDLE;
          endcase
        end
      end
      T5: begin
        case (op_code)
          OP_LDA: begin
            cw_rom[CW_NCE] = 1'b0;
            cw_rom[CW_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cw_rom[CW_NCE] = 1'b0;
            cw_rom[CW_NLB] = 1'b0;
          end
          default: cw_rom = CW_IDLE;
        endcase
      end
      T6: begin
        case (op_code)
          OP_ADD: begin
            cw_rom[CW_EU]  = 1'b1;
            cw_rom[CW_NLA] = 1'b0;
          end
          OP_SUB: begin
            cw_rom[CW_EU]  = 1'b1;
            cw_rom[CW_SU]  = 1'b1;
            cw_rom[CW_NLA] = 1'b0;
          end
          default: cw_rom = CW_IDLE;
        endcase
      end
      default: cw_rom = CW_IDLE;
    endcase
  end

  // clr gates the word immediately so nothing strobes while the ring is being reset.
  assign cont_signal = (clr || halted_q || pause) ? CW_IDLE : cw_rom;
  assign halted      = halted_q;

endmodule

// File: tb/tb_sap1_sequencer.sv
module tb_sap1_sequencer;

  localparam logic [5:0]  S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100;
  localparam logic [5:0]  S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;
  localparam logic [11:0] W_IDLE = 12'h3E3;
  localparam logic [11:0] W_T1   = 12'h5E3;  // Ep, nLm low
  localparam logic [11:0] W_T2   = 12'hBE3;  // CP
  localparam logic [11:0] W_T3   = 12'h263;  // nCE, nLi low
  localparam logic [11:0] W_MEM4 = 12'h1A3;  // nEi, nLm low
  localparam logic [11:0] W_AB5  = 12'h2E1;  // nCE, nLb low
  localparam logic [11:0] W_ADD6 = 12'h3C7;  // Eu, nLa low
  localparam logic [11:0] W_SUB6 = 12'h3CF;  // Eu, Su, nLa low
  localparam logic [11:0] W_LDA5 = 12'h2C3;  // nCE, nLa low
  localparam logic [11:0] W_OUT4 = 12'h3F2;  // Ea, nLo low

  logic        clk, clr, run;
  logic [3:0]  op_code;
  logic [11:0] cw1, cw0;
  logic [5:0]  ts1, ts0;
  logic        h1, h0, d1, d0, i1, i0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         sel;   // 1: EARLY_END=1 instance, 0: EARLY_END=0 instance
    logic [5:0] t;
    logic [11:0] cw;
    logic       done;
    logic       halt;
    logic       ill;
    string      name;
  } exp_t;

  exp_t sb[$];

  sap1_sequencer #(.EARLY_END(1'b1), .HLT_OPCODE(4'hF)) dut (
    .clk(clk), .clr(clr), .run(run), .op_code(op_code),
    .cont_signal(cw1), .t_state(ts1), .halted(h1), .instr_done(d1), .illegal(i1)
  );

  sap1_sequencer #(.EARLY_END(1'b0), .HLT_OPCODE(4'hF)) dut0 (
    .clk(clk), .clr(clr), .run(run), .op_code(op_code),
    .cont_signal(cw0), .t_state(ts0), .halted(h0), .instr_done(d0), .illegal(i0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
    $fatal(1);
  end

  task automatic chk(input string nm, input string fld, input logic [11:0] act,
                     input logic [11:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h want 0x%0h", nm, fld, act, want);
    end
  endtask

  // Monitor: at each rising edge (mid-cycle, away from the falling state edge)
  // compare every expectation queued for the current cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          chk(e.name, "t_state",    {6'd0, ts1}, {6'd0, e.t});
          chk(e.name, "cont",       cw1,         e.cw);
          chk(e.name, "instr_done", {11'd0, d1}, {11'd0, e.done});
          chk(e.name, "halted",     {11'd0, h1}, {11'd0, e.halt});
          chk(e.name, "illegal",    {11'd0, i1}, {11'd0, e.ill});
        end else begin
          chk(e.name, "t_state",    {6'd0, ts0}, {6'd0, e.t});
          chk(e.name, "cont",       cw0,         e.cw);
          chk(e.name, "instr_done", {11'd0, d0}, {11'd0, e.done});
          chk(e.name, "halted",     {11'd0, h0}, {11'd0, e.halt});
          chk(e.name, "illegal",    {11'd0, i0}, {11'd0, e.ill});
        end
      end
    end
  end

  task automatic expect_out(input bit sel, input logic [5:0] t, input logic [11:0] cw,
                            input logic done, input logic halt, input logic ill,
                            input string nm);
    exp_t e;
    e.sel = sel; e.t = t; e.cw = cw; e.done = done; e.halt = halt; e.ill = ill; e.name = nm;
    sb.push_back(e);
  endtask

  // One cycle: state advances on the falling edge, inputs follow 1 ns later.
  task automatic cyc(input logic [3:0] op, input logic r);
    @(negedge clk);
    #1;
    op_code = op;
    run     = r;
  endtask

  // A clr pulse that rises and falls between falling edges: only an async
  // reset can bring the ring back to T1 here.
  task automatic rst_cyc(input logic [3:0] op, input string nm);
    @(negedge clk);
    #1;
    op_code = op;
    run     = 1'b1;
    #1;
    clr = 1'b1;
    expect_out(1'b1, S1, W_IDLE, 1'b0, 1'b0, 1'b0, nm);
    expect_out(1'b0, S1, W_IDLE, 1'b0, 1'b0, 1'b0, nm);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin : stim
    clr = 1'b1; run = 1'b1; op_code = 4'h1;
    #1;
    expect_out(1'b1, S1, W_IDLE, 1'b0, 1'b0, 1'b0, "reset");
    expect_out(1'b0, S1, W_IDLE, 1'b0, 1'b0, 1'b0, "reset0");
    @(negedge clk);
    #1;
    clr = 1'b0;

    // ADD: full six-state instruction, instr_done only in T6
    expect_out(1'b1, S1, W_T1, 1'b0, 1'b0, 1'b0, "add_t1");
    cyc(4'h1, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "add_t2");
    cyc(4'h1, 1'b1); expect_out(1'b1, S3, W_T3,   1'b0, 1'b0, 1'b0, "add_t3");
    cyc(4'h1, 1'b1); expect_out(1'b1, S4, W_MEM4, 1'b0, 1'b0, 1'b0, "add_t4");
    cyc(4'h1, 1'b1); expect_out(1'b1, S5, W_AB5,  1'b0, 1'b0, 1'b0, "add_t5");
    cyc(4'h1, 1'b1); expect_out(1'b1, S6, W_ADD6, 1'b1, 1'b0, 1'b0, "add_t6");
                     expect_out(1'b0, S6, W_ADD6, 1'b1, 1'b0, 1'b0, "add0_t6");

    // SUB: wraps into a new fetch, T6 adds Su
    cyc(4'h2, 1'b1); expect_out(1'b1, S1, W_T1,   1'b0, 1'b0, 1'b0, "sub_t1");
    cyc(4'h2, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "sub_t2");
    cyc(4'h2, 1'b1); expect_out(1'b1, S3, W_T3,   1'b0, 1'b0, 1'b0, "sub_t3");
    cyc(4'h2, 1'b1); expect_out(1'b1, S4, W_MEM4, 1'b0, 1'b0, 1'b0, "sub_t4");
    cyc(4'h2, 1'b1); expect_out(1'b1, S5, W_AB5,  1'b0, 1'b0, 1'b0, "sub_t5");
    cyc(4'h2, 1'b1); expect_out(1'b1, S6, W_SUB6, 1'b1, 1'b0, 1'b0, "sub_t6");

    // LDA: early end after T5 versus full T6 on the EARLY_END=0 instance
    cyc(4'h0, 1'b1); expect_out(1'b1, S1, W_T1,   1'b0, 1'b0, 1'b0, "lda_t1");
    cyc(4'h0, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "lda_t2");
    cyc(4'h0, 1'b1); expect_out(1'b1, S3, W_T3,   1'b0, 1'b0, 1'b0, "lda_t3");
    cyc(4'h0, 1'b1); expect_out(1'b1, S4, W_MEM4, 1'b0, 1'b0, 1'b0, "lda_t4");
    cyc(4'h0, 1'b1); expect_out(1'b1, S5, W_LDA5, 1'b1, 1'b0, 1'b0, "lda_t5");
                     expect_out(1'b0, S5, W_LDA5, 1'b0, 1'b0, 1'b0, "lda0_t5");
    cyc(4'h0, 1'b1); expect_out(1'b1, S1, W_T1,   1'b0, 1'b0, 1'b0, "lda_wrap");
                     expect_out(1'b0, S6, W_IDLE, 1'b1, 1'b0, 1'b0, "lda0_t6");
    cyc(4'hE, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "lda_next_t2");
                     expect_out(1'b0, S1, W_T1,   1'b0, 1'b0, 1'b0, "lda0_wrap");

    // clr while the EARLY_END=1 instance sits in T3
    rst_cyc(4'hE, "clr_mid_t3");

    // OUT with run dropped in T3: instruction completes, then parks at T1
    cyc(4'hE, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "out_t2");
    cyc(4'hE, 1'b0); expect_out(1'b1, S3, W_T3,   1'b0, 1'b0, 1'b0, "out_t3");
    cyc(4'hE, 1'b0); expect_out(1'b1, S4, W_OUT4, 1'b1, 1'b0, 1'b0, "out_t4");
                     expect_out(1'b0, S4, W_OUT4, 1'b0, 1'b0, 1'b0, "out0_t4");
    cyc(4'hE, 1'b0); expect_out(1'b1, S1, W_IDLE, 1'b0, 1'b0, 1'b0, "pause_a");
                     expect_out(1'b0, S5, W_IDLE, 1'b0, 1'b0, 1'b0, "out0_t5");
    cyc(4'hE, 1'b0); expect_out(1'b1, S1, W_IDLE, 1'b0, 1'b0, 1'b0, "pause_b");
                     expect_out(1'b0, S6, W_IDLE, 1'b1, 1'b0, 1'b0, "out0_t6");
    cyc(4'hE, 1'b0); expect_out(1'b1, S1, W_IDLE, 1'b0, 1'b0, 1'b0, "pause_c");
                     expect_out(1'b0, S1, W_IDLE, 1'b0, 1'b0, 1'b0, "pause0");
    cyc(4'h5, 1'b1); expect_out(1'b1, S1, W_T1,   1'b0, 1'b0, 1'b0, "resume_t1");
                     expect_out(1'b0, S1, W_T1,   1'b0, 1'b0, 1'b0, "resume0_t1");

    // Undefined opcode 5
    cyc(4'h5, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "undef_t2");
    cyc(4'h5, 1'b1); expect_out(1'b1, S3, W_T3,   1'b0, 1'b0, 1'b0, "undef_t3");
`ifdef SAP1_ILLEGAL_TRAP_EN
    cyc(4'h5, 1'b1); expect_out(1'b1, S4, W_IDLE, 1'b0, 1'b0, 1'b0, "trap_t4");
    cyc(4'h5, 1'b1); expect_out(1'b1, S4, W_IDLE, 1'b0, 1'b1, 1'b1, "trap_frozen");
                     expect_out(1'b0, S4, W_IDLE, 1'b0, 1'b1, 1'b1, "trap0_frozen");
`else
    cyc(4'h5, 1'b1); expect_out(1'b1, S4, W_IDLE, 1'b1, 1'b0, 1'b0, "nop_t4");
                     expect_out(1'b0, S4, W_IDLE, 1'b0, 1'b0, 1'b0, "nop0_t4");
    cyc(4'h5, 1'b1); expect_out(1'b1, S1, W_T1,   1'b0, 1'b0, 1'b0, "nop_wrap");
                     expect_out(1'b0, S5, W_IDLE, 1'b0, 1'b0, 1'b0, "nop0_t5");
`endif

    // HLT: freezes at T4 with IDLE for 20 clocks regardless of run
    rst_cyc(4'hF, "clr_realign");
    cyc(4'hF, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "hlt_t2");
    cyc(4'hF, 1'b1); expect_out(1'b1, S3, W_T3,   1'b0, 1'b0, 1'b0, "hlt_t3");
    cyc(4'hF, 1'b1); expect_out(1'b1, S4, W_IDLE, 1'b0, 1'b0, 1'b0, "hlt_t4");
    for (int k = 0; k < 20; k++) begin
      cyc(4'hF, (k % 2) == 0);
      expect_out(1'b1, S4, W_IDLE, 1'b0, 1'b1, 1'b0, $sformatf("halted_%0d", k));
      expect_out(1'b0, S4, W_IDLE, 1'b0, 1'b1, 1'b0, $sformatf("halted0_%0d", k));
    end
    rst_cyc(4'h0, "clr_unhalt");
    cyc(4'h0, 1'b1); expect_out(1'b1, S2, W_T2,   1'b0, 1'b0, 1'b0, "after_clr_t2");
                     expect_out(1'b0, S2, W_T2,   1'b0, 1'b0, 1'b0, "after_clr0_t2");

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
